// File: rtl/ram_byte_dumper.sv
// ram_byte_dumper: reads a contiguous run of 32-bit words from basic_ram
// and streams each word out as four bytes, most-significant byte first.
// This undoes the big-endian word packing done by the object-file loader.
module ram_byte_dumper #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_cs_o,
  output logic              mem_we_o,
  output logic              mem_oe_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_done_i,
  output logic [7:0]        byte_data_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i,
  output logic              byte_last_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [31:0]        word_q;
  logic [1:0]         idx_q;

  logic               busy_q;
  logic               done_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               mem_cs_q;
  logic               mem_oe_q;
  logic [7:0]         byte_data_q;
  logic               byte_valid_q;
  logic               byte_last_q;

  logic [ADDR_W-1:0]  addr_d;
  logic [CNT_W-1:0]   remaining_d;
  logic [1:0]         idx_d;

  // Byte idx 0 is the top byte of the word, idx 3 the bottom byte.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Incremented address (wraps naturally), decremented count and next byte index.
  always_comb begin
    addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
    idx_d       = idx_q + 2'd1;
  end

  // Job FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      word_q       <= '0;
      idx_q        <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_cs_q     <= 1'b0;
      mem_oe_q     <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            addr_q      <= start_addr_i;
            remaining_q <= word_count_i;
            busy_q      <= 1'b1;
            if (word_count_i == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= READ;
              mem_addr_q <= start_addr_i;
              mem_cs_q   <= 1'b1;
              mem_oe_q   <= 1'b1;
            end
          end
        end

        READ: begin
          if (mem_done_i) begin
            word_q       <= mem_rdata_i;
            idx_q        <= 2'd0;
            remaining_q  <= remaining_d;
            mem_cs_q     <= 1'b0;
            mem_oe_q     <= 1'b0;
            byte_valid_q <= 1'b1;
            byte_data_q  <= mem_rdata_i[31:24];
            byte_last_q  <= 1'b0;
            state_q      <= SHIFT;
          end
        end

        SHIFT: begin
          if (byte_ready_i) begin
            if (idx_q == 2'd3) begin
              byte_valid_q <= 1'b0;
              byte_last_q  <= 1'b0;
              if (remaining_q != '0) begin
                addr_q     <= addr_d;
                mem_addr_q <= addr_d;
                mem_cs_q   <= 1'b1;
                mem_oe_q   <= 1'b1;
                state_q    <= READ;
              end else begin
                done_q  <= 1'b1;
                state_q <= FIN;
              end
            end else begin
              idx_q       <= idx_d;
              byte_data_q <= pick_byte(word_q, idx_d);
              byte_last_q <= (idx_d == 2'd3) && (remaining_q == '0);
            end
          end
        end

        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_cs_o     = mem_cs_q;
  assign mem_we_o     = 1'b0;
  assign mem_oe_o     = mem_oe_q;
  assign byte_data_o  = byte_data_q;
  assign byte_valid_o = byte_valid_q;
  assign byte_last_o  = byte_last_q;

endmodule

// File: doc/ram_byte_dumper.md
# ram_byte_dumper

Synthesizable reader that drains a contiguous range of 32-bit words out of `basic_ram` and streams them out as bytes, most-significant byte first. It is the inverse of the object-file loader, which packs four file bytes big-endian into one word per address. The dumper unpacks each word back into four bytes in the same order. It sits between `basic_ram`'s read port (`cs`/`oe`/`address`/`data_output`/`mem_done`) and any byte-wide consumer, such as a UART TX, a trace FIFO or a testbench file writer.

## Interface
- `ADDR_W`, 32: width of the word address; addresses wrap modulo 2^ADDR_W.
- `CNT_W`, 16: width of the word-count input.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first word address; captured on accepted `start`.
- `word_count`  in  CNT_W  number of words to dump; captured on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse when the job completes.
- `mem_addr`  out  ADDR_W  RAM word address.
- `mem_cs`  out  1  RAM chip select.
- `mem_we`  out  1  RAM write enable; tied to 0.
- `mem_oe`  out  1  RAM output enable.
- `mem_rdata`  in  32  RAM `data_output`.
- `mem_done`  in  1  RAM access complete; `mem_rdata` is valid in the same cycle.
- `byte_data`  out  8  stream byte.
- `byte_valid`  out  1  stream valid.
- `byte_ready`  in  1  stream ready from the consumer.
- `byte_last`  out  1  marks the final byte of the job.

## Operation
- FSM states: IDLE, READ, SHIFT, FIN.
- **IDLE**
  - On `start`: latch `start_addr` into `addr_q` and `word_count` into `remaining`.
  - If `word_count` == 0: go to FIN (no RAM access, no bytes).
  - Otherwise: go to READ.
- **READ**
  - Drive `mem_cs`=1, `mem_oe`=1, `mem_addr`=`addr_q`.
  - Hold in READ until `mem_done`=1.
  - On that edge: capture `mem_rdata` into `word_q`, clear byte index `idx` to 0, decrement `remaining`, go to SHIFT.
  - There is no timeout; a RAM that never asserts `mem_done` stalls the block until reset.
- **SHIFT**
  - Drive `byte_valid`=1 and `byte_data` = `word_q[31-8*idx -: 8]`: idx 0 gives bits [31:24], idx 3 gives bits [7:0].
  - `mem_cs` and `mem_oe` are low.
  - A byte transfers on an edge where `byte_valid` && `byte_ready`; `idx` then increments.
  - On transfer of idx 3:
    - If `remaining` != 0: `addr_q` <= `addr_q`+1 (wrapping) and go to READ.
    - Otherwise: go to FIN.
- **FIN**: `done`=1 for exactly one cycle, then go to IDLE.
- `byte_last`=1 only in SHIFT with idx==3 and `remaining`==0.
- `byte_data`, `byte_valid` and `byte_last` stay stable while `byte_ready`=0. AXI-style rules apply: valid never drops without a transfer, and valid does not depend on ready.
- `start` while not in IDLE is ignored; the captured job parameters do not change.
- `byte_ready` outside SHIFT is ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `mem_cs`, `mem_oe`, `mem_we`, `byte_valid` and `byte_last` are 0; `mem_addr`, `byte_data` and `word_q` are 0.
- `rst_n` low mid-job aborts immediately and asynchronously. The RAM read in flight is abandoned and no further bytes are emitted.
- All outputs are registered or decoded from registered state only; there is no combinational path from `byte_ready` or `mem_done` to any output.
- Latencies:
  - `start` edge to first `mem_oe`=1: 1 cycle.
  - `mem_done` edge to first `byte_valid`: 1 cycle.
  - Last byte transfer to the next word's `mem_oe`: 1 cycle.
  - Last byte of the job to `done`: 1 cycle.
- Best-case throughput with `byte_ready` tied high and single-cycle `mem_done` is 1 word per 5 cycles plus the RAM latency.
- `busy` = (state != IDLE).
- `word_count` = 0: `done` asserts 1 cycle after `start`, and `busy` is high for that single cycle.

## Test plan
- **Basic dump.** Preload RAM[0..2] = 0x11223344, 0xAABBCCDD, 0x00000001. Pulse start with addr=0, count=3, `byte_ready`=1.
  - Required: bytes 11 22 33 44 AA BB CC DD 00 00 00 01.
  - Required: `byte_last` on the final 01 only, and exactly one `done` pulse.
- **Backpressure.** Same data as the basic dump. Drive `byte_ready` with the pseudo-random pattern 1,0,0,1,0,1…
  - Required: the identical byte sequence, with `byte_data` held stable during every stall.
- **Zero count.** Pulse start with count=0.
  - Required: `done` 1 cycle later, `mem_oe` never high, no `byte_valid`.
- **Start while busy.** During a count=2 job, pulse start with addr=7, count=5.
  - Required: only 8 bytes from the original addresses, and one `done`.
- **Reset mid-job.** Deassert `rst_n` while in SHIFT at idx 2.
  - Required: all outputs return to 0 immediately, and a following clean job dumps correctly.
- **Address wrap.** With `ADDR_W`=4, pulse start with addr=15, count=2.
  - Required: `mem_addr` sequence 15 then 0, and 8 correct bytes.
